// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Data-memory responder for the pipelined MIPS core. It accepts one load/store
// request per handshake, waits LATENCY cycles, commits the store (byte-masked)
// or reads the word, and returns a one-cycle response. It owns the data-memory
// array and drives busy_o, which the hazard logic ORs into the pipeline stall.
//
// Parameters:
//   DEPTH_LOG2  - array holds 2**DEPTH_LOG2 32-bit words (default 10)
//   LATENCY     - wait cycles between accept and access, 0..15 (default 2)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   req_valid_i  in   request present
//   req_ready_o  out  responder can accept a request this cycle
//   req_we_i     in   1 = store, 0 = load
//   req_be_i     in   [3:0] byte enables, lane-aligned
//   req_addr_i   in   [31:0] byte address
//   req_wdata_i  in   [31:0] store data, lane-positioned
//   req_pc_i     in   [31:0] PC of the requester (write log only)
//   rsp_valid_o  out  one-cycle response pulse
//   rsp_rdata_o  out  [31:0] word read; 0 for stores and errors
//   rsp_err_o    out  request rejected (qualified by rsp_valid_o)
//   busy_o       out  pipeline must hold the M stage
//
// Optional feature: define DM_DISPLAY_EN to print a write-log line for every
// committed, non-error store.
// -----------------------------------------------------------------------------
module dm_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [3:0]  req_be_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [31:0] req_pc_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        busy_o
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;

   // Request latched at accept
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] pc_q;

   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rsp_rdata_q;

   logic [31:0] mem_q [DEPTH];

   logic                  accept;
   logic                  in_wait;
   logic                  do_access;
   logic                  acc_we;
   logic [3:0]            acc_be;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic [31:0]           acc_pc;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic                  be_ok;
   logic                  addr_ok;
   logic                  acc_err;
   logic [31:0]           mem_word_d;

   assign req_ready_o = (state_q != S_WAIT);
   assign accept      = req_valid_i & req_ready_o;
   // Combinational from req_valid_i so the stall asserts in the accept cycle.
   assign busy_o      = (state_q == S_WAIT) | accept;

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

   // The access uses the latched request after a countdown, or the live request
   // when LATENCY is 0 and the access happens on the accept edge itself.
   assign in_wait   = (state_q == S_WAIT);
   assign do_access = in_wait ? (cnt_q == 4'd0) : ((LATENCY == 0) && accept);

   assign acc_we    = in_wait ? we_q    : req_we_i;
   assign acc_be    = in_wait ? be_q    : req_be_i;
   assign acc_addr  = in_wait ? addr_q  : req_addr_i;
   assign acc_wdata = in_wait ? wdata_q : req_wdata_i;
   assign acc_pc    = in_wait ? pc_q    : req_pc_i;
   assign acc_idx   = acc_addr[DEPTH_LOG2+1:2];

   // Only naturally aligned byte, halfword and word enables are legal.
   always_comb begin
      be_ok = 1'b0;
      case (acc_be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
         default:                   be_ok = 1'b0;
      endcase
   end

   // Addresses beyond the array are rejected rather than aliased.
   assign addr_ok = (acc_addr[31:DEPTH_LOG2+2] == '0);
   assign acc_err = ~be_ok | ~addr_ok;

   // Byte-merge of store data into the current word.
   always_comb begin
      mem_word_d = mem_q[acc_idx];
      for (int i = 0; i < 4; i++) begin
         if (acc_be[i]) mem_word_d[8*i +: 8] = acc_wdata[8*i +: 8];
      end
   end

   // NOTE: the array is cleared by reset because a reset must leave every word
   // reading 0; this forces flops rather than a RAM macro.
   // NOTE: every register here is assigned with <= so all state updates see
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         pc_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;

         case (state_q)
            S_IDLE, S_RESP: begin
               if (accept) begin
                  we_q    <= req_we_i;
                  be_q    <= req_be_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  pc_q    <= req_pc_i;
                  if (LATENCY == 0) begin
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_WAIT: begin
               // req_valid_i is ignored while counting down.
               if (cnt_q == 4'd0) state_q <= S_RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            default: state_q <= S_IDLE;
         endcase

         if (do_access) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            if (!acc_err && acc_we) begin
               mem_q[acc_idx] <= mem_word_d;
`ifdef DM_DISPLAY_EN
               $display("@%08h: *%08h <= %08h", acc_pc, {acc_addr[31:2], 2'b00}, mem_word_d);
`endif
            end
            rsp_rdata_q <= (acc_err || acc_we) ? 32'd0 : mem_q[acc_idx];
         end
      end
   end

   // Bits with no function in this build, collected so they are not flagged.
   logic unused_ok;
`ifdef DM_DISPLAY_EN
   assign unused_ok = ^acc_addr[1:0];
`else
   assign unused_ok = ^{acc_addr[1:0], acc_pc};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//
// Directed bench for dm_responder. u_dut runs with LATENCY=2, u_dut0 with
// LATENCY=0; both share the request buses but have separate req_valid lines.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_valid0;
   logic        req_we;
   logic [3:0]  req_be;
   logic [31:0] req_addr, req_wdata, req_pc;

   logic        ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        ready0, rsp_valid0, rsp_err0, busy0;
   logic [31:0] rsp_rdata0;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dm_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (ready),
      .req_we_i    (req_we),
      .req_be_i    (req_be),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_pc_i    (req_pc),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .busy_o      (busy)
   );

   dm_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid0),
      .req_ready_o (ready0),
      .req_we_i    (req_we),
      .req_be_i    (req_be),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_pc_i    (req_pc),
      .rsp_valid_o (rsp_valid0),
      .rsp_rdata_o (rsp_rdata0),
      .rsp_err_o   (rsp_err0),
      .busy_o      (busy0)
   );

   task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc);
      req_we    = we;
      req_be    = be;
      req_addr  = addr;
      req_wdata = wdata;
      req_pc    = pc;
   endtask

   // One request on u_dut; returns the response and the number of cycles from
   // the accept edge to the response (bounded at 20).
   task automatic transact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc,
                           output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      drive(we, be, addr, wdata, pc);
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 1'b0;
      req_valid0 = 1'b0;
      drive(1'b0, 4'hF, 32'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset rsp_err: got %b want 0", rsp_err); end
      vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset rsp_rdata: got %h want 0", rsp_rdata); end
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset req_ready: got %b want 1", ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
      vectors++; if (rsp_valid0 !== 1'b0 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
         miscompares++; $display("FAIL reset lat0 valid/ready/busy: got %b%b%b want 010", rsp_valid0, ready0, busy0);
      end
      rst = 1'b0;
   endtask

   task automatic test_store_timing;
      logic [31:0] rd;
      logic        er;
      int          lat;
      @(negedge clk);
      drive(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h3000);
      req_valid = 1'b1;
      #1;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL timing busy at accept: got %b want 1", busy); end
      @(posedge clk);                                 // E0
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++; $display("FAIL timing after E0 valid/busy: got %b%b want 01", rsp_valid, busy);
      end
      @(negedge clk);                                 // after E1
      vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++; $display("FAIL timing after E1 valid/busy: got %b%b want 01", rsp_valid, busy);
      end
      @(negedge clk);                                 // after E2
      vectors++; if (rsp_valid !== 1'b1 || busy !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
         miscompares++; $display("FAIL timing after E2 valid/busy/err/rdata: got %b%b%b %h want 100 00000000",
                                 rsp_valid, busy, rsp_err, rsp_rdata);
      end
      @(negedge clk);                                 // after E3
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL timing pulse width: got %b want 0", rsp_valid); end
      transact(1'b0, 4'b1111, 32'h10, 32'h0, 32'h3004, rd, er, lat);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load latency: got %0d want 2", lat); end
      vectors++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         miscompares++; $display("FAIL load 0x10: got %h err %b want deadbeef err 0", rd, er);
      end
   endtask

   task automatic test_byte_merge;
      logic [31:0] rd;
      logic        er;
      int          lat;
      transact(1'b1, 4'b1111, 32'h10, 32'h11223344, 32'h3010, rd, er, lat);
      transact(1'b1, 4'b0100, 32'h12, 32'h00AB0000, 32'h3014, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL byte store err: got %b want 0", er); end
      transact(1'b0, 4'b1111, 32'h10, 32'h0, 32'h3018, rd, er, lat);
      vectors++; if (rd !== 32'h11AB3344) begin miscompares++; $display("FAIL byte merge: got %h want 11ab3344", rd); end
      transact(1'b1, 4'b0011, 32'h10, 32'h0000BEEF, 32'h301C, rd, er, lat);
      transact(1'b1, 4'b1000, 32'h13, 32'h77000000, 32'h3020, rd, er, lat);
      transact(1'b0, 4'b1111, 32'h10, 32'h0, 32'h3024, rd, er, lat);
      vectors++; if (rd !== 32'h77ABBEEF) begin miscompares++; $display("FAIL half+byte merge: got %h want 77abbeef", rd); end
   endtask

   task automatic test_errors;
      logic [31:0] rd;
      logic        er;
      int          lat;
      transact(1'b1, 4'b0101, 32'h10, 32'hFFFFFFFF, 32'h3030, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL bad be store: got err %b rdata %h want 1 0", er, rd); end
      transact(1'b1, 4'b1111, 32'h1010, 32'h0, 32'h3034, rd, er, lat);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL range store err: got %b want 1", er); end
      transact(1'b0, 4'b1111, 32'h1010, 32'h0, 32'h3038, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL range load: got err %b rdata %h want 1 0", er, rd); end
      transact(1'b0, 4'b0000, 32'h10, 32'h0, 32'h303C, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL be0 load: got err %b rdata %h want 1 0", er, rd); end
      transact(1'b0, 4'b1111, 32'h10, 32'h0, 32'h3040, rd, er, lat);
      vectors++; if (er !== 1'b0 || rd !== 32'h77ABBEEF) begin
         miscompares++; $display("FAIL memory after errors: got err %b rdata %h want 0 77abbeef", er, rd);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      drive(1'b1, 4'b1111, 32'h30, 32'hCAFEF00D, 32'h3050);
      req_valid = 1'b1;
      @(posedge clk);                                 // E0: accept store
      @(negedge clk);
      drive(1'b0, 4'b1111, 32'h30, 32'h0, 32'h3054); // held through WAIT, ignored
      @(negedge clk);                                 // after E1
      @(negedge clk);                                 // after E2: store response
      #1;
      vectors++; if (rsp_valid !== 1'b1 || ready !== 1'b1 || busy !== 1'b1) begin
         miscompares++; $display("FAIL b2b first rsp valid/ready/busy: got %b%b%b want 111", rsp_valid, ready, busy);
      end
      @(negedge clk);                                 // after E3: load accepted in RESP
      req_valid = 1'b0;
      vectors++; if (rsp_valid !== 1'b0 || ready !== 1'b0) begin
         miscompares++; $display("FAIL b2b after E3 valid/ready: got %b%b want 00", rsp_valid, ready);
      end
      @(negedge clk);                                 // after E4
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b after E4 valid: got %b want 0", rsp_valid); end
      @(negedge clk);                                 // after E5
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
         miscompares++; $display("FAIL b2b load: got valid %b rdata %h want 1 cafef00d", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_latency0;
      @(negedge clk);
      drive(1'b1, 4'b1111, 32'h40, 32'h0000AAAA, 32'h3060);
      req_valid0 = 1'b1;
      #1;
      vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL lat0 busy: got %b want 1", busy0); end
      @(negedge clk);                                 // after E0
      vectors++; if (rsp_valid0 !== 1'b1 || rsp_err0 !== 1'b0) begin
         miscompares++; $display("FAIL lat0 rsp1 valid/err: got %b%b want 10", rsp_valid0, rsp_err0);
      end
      drive(1'b1, 4'b1111, 32'h44, 32'h00005555, 32'h3064);
      @(negedge clk);                                 // after E1
      vectors++; if (rsp_valid0 !== 1'b1 || ready0 !== 1'b1) begin
         miscompares++; $display("FAIL lat0 rsp2 valid/ready: got %b%b want 11", rsp_valid0, ready0);
      end
      drive(1'b0, 4'b1111, 32'h40, 32'h0, 32'h3068);
      @(negedge clk);                                 // after E2
      vectors++; if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 32'h0000AAAA) begin
         miscompares++; $display("FAIL lat0 rsp3: got valid %b rdata %h want 1 0000aaaa", rsp_valid0, rsp_rdata0);
      end
      req_valid0 = 1'b0;
      @(negedge clk);                                 // after E3
      vectors++; if (rsp_valid0 !== 1'b0) begin miscompares++; $display("FAIL lat0 idle: got %b want 0", rsp_valid0); end
   endtask

   task automatic test_reset_mid_wait;
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        seen;
      @(negedge clk);
      drive(1'b1, 4'b1111, 32'h20, 32'h12345678, 32'h3070);
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      vectors++; if (busy !== 1'b1 || ready !== 1'b0) begin
         miscompares++; $display("FAIL wait state busy/ready: got %b%b want 10", busy, ready);
      end
      rst = 1'b1;
      #1;
      vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
         miscompares++; $display("FAIL reset mid wait valid/busy/ready: got %b%b%b want 001", rsp_valid, busy, ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL stray response after reset: got %b want 0", seen); end
      transact(1'b0, 4'b1111, 32'h20, 32'h0, 32'h3074, rd, er, lat);
      vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("FAIL load 0x20 after reset: got %h err %b want 0 0", rd, er); end
      transact(1'b0, 4'b1111, 32'h10, 32'h0, 32'h3078, rd, er, lat);
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL array clear 0x10: got %h want 0", rd); end
   endtask

   task automatic test_reset_in_resp;
      logic [31:0] rd;
      logic        er;
      int          lat;
      transact(1'b1, 4'b1111, 32'h24, 32'h1, 32'h3080, rd, er, lat);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL resp before reset latency: got %0d want 2", lat); end
      #1;
      rst = 1'b1;
      #1;
      vectors++; if (rsp_valid !== 1'b0 || ready !== 1'b1) begin
         miscompares++; $display("FAIL async reset in RESP valid/ready: got %b%b want 01", rsp_valid, ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_display;
      logic [31:0] rd;
      logic        er;
      int          lat;
      transact(1'b1, 4'b1111, 32'h4, 32'h5, 32'h00003008, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL logged store err: got %b want 0", er); end
      transact(1'b0, 4'b1111, 32'h4, 32'h0, 32'h0000300C, rd, er, lat);
      vectors++; if (rd !== 32'h5) begin miscompares++; $display("FAIL logged store readback: got %h want 5", rd); end
   endtask

   initial begin
      test_reset;
      test_store_timing;
      test_byte_merge;
      test_errors;
      test_back_to_back;
      test_latency0;
      test_reset_mid_wait;
      test_reset_in_resp;
      test_display;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined MIPS core. It sits on the far side of the M-stage load/store port: it accepts one request per handshake, waits a fixed number of cycles, commits the write or reads the word, and returns a one-cycle response. It owns the data-memory array and produces a `busy` signal that the hazard logic ORs into the pipeline stall.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: number of 32-bit words in the array is 2^DEPTH_LOG2.
- `LATENCY`, default 2, legal range 0..15: extra wait cycles between accept and access.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_be` in 4: byte enables, already lane-aligned by the requester.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, already lane-positioned.
- `req_pc` in 32: PC of the requesting instruction, used only for the write log.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: full word read; 0 for stores and errors.
- `rsp_err` out 1: request rejected (qualified by `rsp_valid`).
- `busy` out 1: pipeline must hold the M stage.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state != WAIT).
- Accept happens when `req_valid & req_ready`. On accept, latch we, be, addr, wdata and pc.
  - If LATENCY == 0, go to RESP and perform the access on the same edge.
  - Otherwise go to WAIT with `cnt` = LATENCY-1.
- In WAIT:
  - If `cnt` == 0, perform the access and go to RESP.
  - Otherwise decrement `cnt`.
  - `req_valid` is ignored.
- In RESP, `rsp_valid` = 1 for exactly one cycle. Next state:
  - RESP again (new access path as above) if a new request is accepted this cycle.
  - Otherwise IDLE.
- Access at word index `addr[DEPTH_LOG2+1:2]`:
  - Store: update only the bytes with `be[i]` set.
  - Load: `rsp_rdata` = the whole word.
- Error: `be` not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}, or `addr[31:DEPTH_LOG2+2]` != 0. An erroring request never writes, returns `rsp_err` = 1 and `rsp_rdata` = 0.
- `busy` = (state == WAIT) | (`req_valid` & `req_ready`). This path is combinational from `req_valid`.
- Requester rule: deassert `req_valid` in the cycle after accept unless issuing a new request.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0, `req_ready` = 1, `busy` = 0. All array words are cleared to 0.
- Accept edge E0: `rsp_valid` is high in the cycle following edge E0+LATENCY. The write is visible to any request accepted at or after that edge.
- Back-to-back: a request accepted in RESP starts a new countdown. Throughput is one request per LATENCY+1 cycles.
- Reset mid-WAIT: the latched request is discarded with no write, and no response is ever produced.
- Reset in RESP: `rsp_valid` drops immediately (asynchronous).
- Load after store to the same word: returns the merged post-store word.

## Configuration
- `DM_DISPLAY_EN` defined: on every committed, non-error store, print at the commit edge `"@<pc hex>: *<word-aligned addr hex> <= <merged word hex>"` with `$display`.
- `DM_DISPLAY_EN` undefined: no display statements are compiled; behaviour is otherwise identical.

## Test plan
- Reset, then LATENCY=2, store be=1111 addr 0x10 wdata 0xDEADBEEF accepted at edge 0. Required: `rsp_valid` high only in the cycle after edge 2, `busy` high in the cycles after edges 0 and 1. A following load of 0x10 returns 0xDEADBEEF.
- Store be=0100 addr 0x12 wdata 0x00AB0000 onto word 0x11223344. A load of 0x10 returns 0x11AB3344.
- Illegal be=0101, or addr 0x00001000 with DEPTH_LOG2=10. Required: `rsp_err` = 1, `rsp_rdata` = 0, memory unchanged.
- LATENCY=0: requests accepted on three consecutive edges. Required: `rsp_valid` stays high for three consecutive cycles and state stays in RESP.
- Assert `rst` while in WAIT of a store to 0x20. Required: no `rsp_valid`, outputs at reset values, and a later load of 0x20 returns 0.
- With `DM_DISPLAY_EN` defined, a store at pc 0x00003008 of 0x5 to addr 0x4 prints `"@00003008: *00000004 <= 00000005"` exactly once. Without the macro, nothing is printed.
